// File: rtl/seven_seg_pkg.sv
// Shared constants for the 7-segment encoder/decoder pair.
// Segment patterns are active-low, bit order abc_defg (bit6=a ... bit0=g).
package seven_seg_pkg;

  localparam logic [6:0] BLANK = 7'b111_1111;
  localparam logic [6:0] ZERO  = 7'b000_0001;
  localparam logic [6:0] ONE   = 7'b100_1111;
  localparam logic [6:0] TWO   = 7'b001_0010;
  localparam logic [6:0] THREE = 7'b000_0110;
  localparam logic [6:0] FOUR  = 7'b100_1100;
  localparam logic [6:0] FIVE  = 7'b010_0100;
  localparam logic [6:0] SIX   = 7'b010_0000;
  localparam logic [6:0] SEVEN = 7'b000_1111;
  localparam logic [6:0] EIGHT = 7'b000_0000;
  localparam logic [6:0] NINE  = 7'b000_0100;

  // Nibble codes reported for non-digit patterns.
  localparam logic [3:0] NIB_BLANK = 4'hF;
  localparam logic [3:0] NIB_ERR   = 4'hE;

  // Run counter width; the counter saturates and never wraps.
  localparam int CNT_W = 8;

  // Frame assembly states.
  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } cap_state_e;

endpackage

// File: rtl/seven_seg_pattern_dec.sv
// Combinational decode of one active-low segment pattern into a BCD nibble,
// plus blank/error flags for patterns that are not a digit.
module seven_seg_pattern_dec
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       blank_o,
  output logic       err_o
);

  // Pattern lookup; anything unrecognised is flagged as an error.
  always_comb begin
    nibble_o = NIB_ERR;
    blank_o  = 1'b0;
    err_o    = 1'b0;
    case (seg_i)
      ZERO:    nibble_o = 4'd0;
      ONE:     nibble_o = 4'd1;
      TWO:     nibble_o = 4'd2;
      THREE:   nibble_o = 4'd3;
      FOUR:    nibble_o = 4'd4;
      FIVE:    nibble_o = 4'd5;
      SIX:     nibble_o = 4'd6;
      SEVEN:   nibble_o = 4'd7;
      EIGHT:   nibble_o = 4'd8;
      NINE:    nibble_o = 4'd9;
      BLANK: begin
        nibble_o = NIB_BLANK;
        blank_o  = 1'b1;
      end
      default: begin
        nibble_o = NIB_ERR;
        err_o    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seven_seg_dec_capture.sv
// Reader for a 4-digit multiplexed 7-segment bus. Each {An,Seg} pattern must
// be stable for STABLE_CYCLES samples before it is captured into its digit
// slot; once all digits are seen the frame is emitted with a one-cycle Valid.
module seven_seg_dec_capture
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 8,
  parameter int DIGITS        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            Seg,
  input  logic [DIGITS-1:0]     An,
  output logic [4*DIGITS-1:0]   Value,
  output logic                  Valid,
  output logic [DIGITS-1:0]     DigBlank,
  output logic [DIGITS-1:0]     DigErr
);

  localparam int               IDX_W      = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_M1  = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]            s_seg_q;
  logic [DIGITS-1:0]     s_an_q;
  logic [DIGITS+6:0]     prev_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIGITS-1:0]     mask_q, mask_d;
  cap_state_e            state_q, state_d;
  logic [3:0]            slot_nib_q [DIGITS];
  logic [DIGITS-1:0]     slot_blank_q, slot_err_q;
  logic [4*DIGITS-1:0]   value_q, value_d;
  logic [DIGITS-1:0]     blank_q, blank_d, err_q, err_d;
  logic                  valid_q, valid_d;

  logic                  same;
  logic                  one_low;
  logic                  capture;
  logic [IDX_W-1:0]      cap_idx;
  logic [DIGITS-1:0]     cap_bit;
  logic [DIGITS-1:0]     an_act;
  logic [3:0]            dec_nib;
  logic                  dec_blank, dec_err;

  seven_seg_pattern_dec u_dec (
    .seg_i    (s_seg_q),
    .nibble_o (dec_nib),
    .blank_o  (dec_blank),
    .err_o    (dec_err)
  );

  // Stability tracking and capture qualification on the registered sample.
  always_comb begin
    same    = ({s_an_q, s_seg_q} == prev_q);
    an_act  = ~s_an_q;
    one_low = (an_act != '0) && ((an_act & (an_act - 1'b1)) == '0);
    cap_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!s_an_q[i]) cap_idx = IDX_W'(i);
    end
    if (!same)                   cnt_d = CNT_W'(1);
    else if (cnt_q == STABLE_MAX) cnt_d = cnt_q;
    else                         cnt_d = cnt_q + 1'b1;
    // Only the transition into STABLE_MAX fires, so a run captures once.
    capture = same && (cnt_q == STABLE_M1) && one_low;
    cap_bit = capture ? (DIGITS'(1) << cap_idx) : '0;
  end

  // Frame FSM: collect digits, then emit the assembled frame for one cycle.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    valid_d = 1'b0;
    value_d = value_q;
    blank_d = blank_q;
    err_d   = err_q;
    case (state_q)
      COLLECT: begin
        mask_d = mask_q | cap_bit;
        if (mask_d == '1) state_d = EMIT;
      end
      EMIT: begin
        // A capture landing here starts the next frame instead of being lost.
        mask_d  = cap_bit;
        valid_d = 1'b1;
        for (int i = 0; i < DIGITS; i++) value_d[4*i +: 4] = slot_nib_q[i];
        blank_d = slot_blank_q;
        err_d   = slot_err_q;
        state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  // Input sampling, run counter, digit slots and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg_q      <= BLANK;
      s_an_q       <= '1;
      prev_q       <= {{DIGITS{1'b1}}, BLANK};
      cnt_q        <= '0;
      mask_q       <= '0;
      state_q      <= COLLECT;
      slot_blank_q <= '0;
      slot_err_q   <= '0;
      for (int i = 0; i < DIGITS; i++) slot_nib_q[i] <= '0;
      value_q      <= '0;
      blank_q      <= '0;
      err_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      s_seg_q <= Seg;
      s_an_q  <= An;
      prev_q  <= {s_an_q, s_seg_q};
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      state_q <= state_d;
      if (capture) begin
        slot_nib_q[cap_idx]   <= dec_nib;
        slot_blank_q[cap_idx] <= dec_blank;
        slot_err_q[cap_idx]   <= dec_err;
      end
      value_q <= value_d;
      blank_q <= blank_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  assign Value    = value_q;
  assign Valid    = valid_q;
  assign DigBlank = blank_q;
  assign DigErr   = err_q;

endmodule

// File: tb/tb_seven_seg_dec_capture.sv
// Bench for seven_seg_dec_capture: directed frames plus randomized holds,
// scored against a hold-level model of the capture rules.
module tb_seven_seg_dec_capture;

  localparam int STABLE = 8;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_in = 7'h7F;
  logic [3:0]  an_in  = 4'hF;
  logic [15:0] value;
  logic        valid;
  logic [3:0]  dig_blank, dig_err;

  always #5 clk = ~clk;

  seven_seg_dec_capture #(.STABLE_CYCLES(STABLE), .DIGITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .Seg      (seg_in),
    .An       (an_in),
    .Value    (value),
    .Valid    (valid),
    .DigBlank (dig_blank),
    .DigErr   (dig_err)
  );

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  int          valid_cnt = 0;
  bit          mon_en = 1'b0;
  logic [23:0] exp_q[$];
  logic [23:0] held_exp = '0;
  logic [23:0] last_out = '0;

  // Reference digit table, index = digit value.
  logic [6:0] seg_tab [10] = '{7'b000_0001, 7'b100_1111, 7'b001_0010, 7'b000_0110,
                               7'b100_1100, 7'b010_0100, 7'b010_0000, 7'b000_1111,
                               7'b000_0000, 7'b000_0100};

  // Model: slots/mask per frame, and the current run of identical patterns.
  logic [3:0]  m_nib [4];
  logic [3:0]  m_blank, m_err, m_mask;
  logic [10:0] m_prev;
  int          m_run;
  bit          m_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_mask  = '0;
    m_blank = '0;
    m_err   = '0;
    for (int i = 0; i < 4; i++) m_nib[i] = '0;
    m_prev = {4'hF, 7'h7F};
    m_run  = 1;
    m_done = 1'b0;
  endtask

  // Apply one hold of `len` cycles to the model: a run captures once when it
  // reaches STABLE identical samples and exactly one digit enable is low.
  task automatic model_hold(input logic [3:0] a, input logic [6:0] s, input int len);
    int          idx;
    logic [3:0]  nib;
    logic        b, e;
    logic [15:0] v;
    if ({a, s} == m_prev) m_run += len;
    else begin
      m_prev = {a, s};
      m_run  = len;
      m_done = 1'b0;
    end
    if (!m_done && m_run >= STABLE && $countones(~a) == 1) begin
      m_done = 1'b1;
      idx = 0;
      for (int i = 0; i < 4; i++) if (!a[i]) idx = i;
      nib = 4'hE; b = 1'b0; e = 1'b1;
      if (s == 7'h7F) begin nib = 4'hF; b = 1'b1; e = 1'b0; end
      for (int d = 0; d < 10; d++) if (seg_tab[d] == s) begin nib = 4'(d); e = 1'b0; end
      m_nib[idx]   = nib;
      m_blank[idx] = b;
      m_err[idx]   = e;
      m_mask[idx]  = 1'b1;
      if (m_mask == 4'hF) begin
        for (int i = 0; i < 4; i++) v[4*i +: 4] = m_nib[i];
        exp_q.push_back({v, m_blank, m_err});
        m_mask = '0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int len);
    model_hold(a, s, len);
    an_in  = a;
    seg_in = s;
    repeat (len) @(negedge clk);
  endtask

  task automatic hold_digit(input int d, input logic [6:0] s, input int len);
    logic [3:0] a;
    a = ~(4'b0001 << d);
    hold(a, s, len);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    an_in  = 4'hF;
    seg_in = 7'h7F;
    @(negedge clk);
    held_exp = '0;
    check_eq("rst_value", value, 16'h0000);
    check_eq("rst_valid", valid, 1'b0);
    check_eq("rst_blank", dig_blank, 4'h0);
    check_eq("rst_err",   dig_err, 4'h0);
    model_clear();
    mon_en = 1'b1;
    rst    = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (valid) begin
        valid_cnt++;
        last_out = {value, dig_blank, dig_err};
        if (exp_q.size() == 0) check_eq("valid_unexpected", valid, 1'b0);
        else begin
          held_exp = exp_q.pop_front();
          check_eq("frame", last_out, held_exp);
        end
      end else begin
        check_eq("hold_outputs", {value, dig_blank, dig_err}, held_exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int v0;
    logic [3:0] a;
    logic [6:0] s;
    repeat (2) @(negedge clk);
    do_reset();
    hold(4'hF, 7'h7F, 4);

    // Frame 1,2,3,4 on digits 3..0.
    v0 = valid_cnt;
    hold_digit(3, seg_tab[1], 16);
    hold_digit(2, seg_tab[2], 16);
    hold_digit(1, seg_tab[3], 16);
    hold_digit(0, seg_tab[4], 16);
    hold(4'hF, 7'h7F, 8);
    check_eq("t1_valids", valid_cnt - v0, 1);
    check_eq("t1_frame", last_out, {16'h1234, 4'h0, 4'h0});

    // Same frame with a short glitch in the middle of digit 1.
    v0 = valid_cnt;
    hold_digit(3, seg_tab[1], 16);
    hold_digit(2, seg_tab[2], 16);
    hold_digit(1, seg_tab[3], 6);
    hold_digit(1, 7'b000_0000, 5);
    hold_digit(1, seg_tab[3], 10);
    hold_digit(0, seg_tab[4], 16);
    hold(4'hF, 7'h7F, 8);
    check_eq("t2_valids", valid_cnt - v0, 1);
    check_eq("t2_frame", last_out, {16'h1234, 4'h0, 4'h0});

    // Blank leading digit.
    hold_digit(3, 7'h7F, 16);
    hold_digit(2, seg_tab[0], 16);
    hold_digit(1, seg_tab[0], 16);
    hold_digit(0, seg_tab[7], 16);
    hold(4'hF, 7'h7F, 8);
    check_eq("t3_frame", last_out, {16'hF007, 4'b1000, 4'h0});

    // Illegal pattern on digit 0.
    hold_digit(3, seg_tab[9], 16);
    hold_digit(2, seg_tab[8], 16);
    hold_digit(1, seg_tab[5], 16);
    hold_digit(0, 7'b111_1110, 16);
    hold(4'hF, 7'h7F, 8);
    check_eq("t4_frame", last_out, {16'h985E, 4'h0, 4'b0001});

    // Multi-low and all-off enables never capture.
    v0 = valid_cnt;
    hold(4'b1100, seg_tab[3], 20);
    hold(4'hF, seg_tab[3], 20);
    check_eq("t5_valids", valid_cnt - v0, 0);
    check_eq("t5_mask", dut.mask_q, 4'h0);

    // Partial frame discarded by reset.
    hold_digit(0, seg_tab[1], 16);
    hold_digit(1, seg_tab[2], 16);
    v0 = valid_cnt;
    do_reset();
    hold_digit(3, seg_tab[5], 16);
    hold_digit(2, seg_tab[6], 16);
    hold_digit(1, seg_tab[7], 16);
    hold_digit(0, seg_tab[8], 16);
    hold(4'hF, 7'h7F, 8);
    check_eq("t6_valids", valid_cnt - v0, 1);
    check_eq("t6_frame", last_out, {16'h5678, 4'h0, 4'h0});

    // Randomized holds, including short runs and odd enables/patterns.
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    a = 4'($urandom_range(0, 15));
        2:       a = 4'hF;
        default: a = ~(4'b0001 << $urandom_range(0, 3));
      endcase
      case ($urandom_range(0, 9))
        0:       s = 7'h7F;
        1, 2:    s = 7'($urandom_range(0, 127));
        default: s = seg_tab[$urandom_range(0, 9)];
      endcase
      hold(a, s, $urandom_range(1, 20));
    end
    hold(4'hF, 7'h7F, 20);
    check_eq("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
